// File: rtl/telemetry_pkg.sv
// Constants, byte-FSM state type and checksum helper shared by the telemetry framer.
package telemetry_pkg;
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam int unsigned PKT_BYTES = 4;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  function automatic logic [7:0] calc_chk(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c);
    return a ^ b ^ c;
  endfunction
endpackage

// File: rtl/uart_byte_tx.sv
// Single UART byte transmitter (start, 8 data bits LSB first, stop).
// A load during the final stop-bit cycle chains the next byte with no idle gap.
module uart_byte_tx
  import telemetry_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] byte_in,
  output logic       tx,
  output logic       byte_done
);
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  state_t      r_state, w_state_next;
  logic [15:0] r_baud, w_baud_next;
  logic [2:0]  r_bit, w_bit_next;
  logic [7:0]  r_shift, w_shift_next;
  logic        r_tx, w_tx_next;
  logic        r_done, w_done_next;
  logic        w_bit_end;

  assign w_bit_end = (r_baud == BAUD_LAST);
  assign tx        = r_tx;
  assign byte_done = r_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_baud  <= w_baud_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
      r_done  <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_baud_next  = r_baud;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_tx_next    = r_tx;
    case (r_state)
      IDLE: begin
        if (load) begin
          w_state_next = START;
          w_baud_next  = '0;
          w_shift_next = byte_in;
          w_tx_next    = 1'b0;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_next = DATA;
          w_baud_next  = '0;
          w_bit_next   = '0;
          w_tx_next    = r_shift[0];
        end else begin
          w_baud_next = r_baud + 16'd1;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_baud_next = '0;
          if (r_bit == 3'd7) begin
            w_state_next = STOP;
            w_tx_next    = 1'b1;
          end else begin
            w_bit_next   = r_bit + 3'd1;
            w_shift_next = {1'b0, r_shift[7:1]};
            w_tx_next    = r_shift[1];
          end
        end else begin
          w_baud_next = r_baud + 16'd1;
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_baud_next = '0;
          if (load) begin
            w_state_next = START;
            w_shift_next = byte_in;
            w_tx_next    = 1'b0;
          end else begin
            w_state_next = IDLE;
            w_tx_next    = 1'b1;
          end
        end else begin
          w_baud_next = r_baud + 16'd1;
        end
      end
      default: w_state_next = IDLE;
    endcase
    // Registered look-ahead so byte_done is high exactly on the last stop-bit cycle.
    w_done_next = (w_state_next == STOP) && (w_baud_next == BAUD_LAST);
  end
endmodule

// File: rtl/telemetry_frame_tx.sv
// Telemetry framer: snapshots vout/data on a trigger and sends A5, vout, data, checksum over UART.
// Owns the snapshot, byte index, auto-trigger timer and saturating drop counter.
module telemetry_frame_tx
  import telemetry_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned AUTO_PERIOD  = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] vout_in,
  input  logic [7:0] data_in,
  input  logic       sample_req,
  output logic       tx,
  output logic       busy,
  output logic       pkt_done,
  output logic [3:0] drop_cnt
);
  localparam logic [1:0] LAST_IDX = 2'(PKT_BYTES - 1);

  logic       r_busy;
  logic [1:0] r_byte_idx;
  logic [7:0] r_vout, r_data, r_chk;
  logic [3:0] r_drop;
  logic       w_auto_fire, w_trigger, w_chain, w_pkt_end, w_load, w_byte_done;
  logic [7:0] w_byte;

  assign w_trigger = !r_busy && (sample_req || w_auto_fire);
  assign w_chain   = r_busy && w_byte_done && (r_byte_idx != LAST_IDX);
  assign w_pkt_end = r_busy && w_byte_done && (r_byte_idx == LAST_IDX);
  assign w_load    = w_trigger || w_chain;

  assign busy     = r_busy;
  assign pkt_done = w_pkt_end;
  assign drop_cnt = r_drop;

  always_comb begin
    w_byte = SYNC_BYTE;
    if (w_chain) begin
      case (r_byte_idx)
        2'd0:    w_byte = r_vout;
        2'd1:    w_byte = r_data;
        default: w_byte = r_chk;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy     <= 1'b0;
      r_byte_idx <= '0;
      r_vout     <= '0;
      r_data     <= '0;
      r_chk      <= '0;
      r_drop     <= '0;
    end else begin
      if (w_trigger) begin
        r_busy     <= 1'b1;
        r_byte_idx <= '0;
        r_vout     <= vout_in;
        r_data     <= data_in;
        r_chk      <= calc_chk(SYNC_BYTE, vout_in, data_in);
      end else if (w_chain) begin
        r_byte_idx <= r_byte_idx + 2'd1;
      end else if (w_pkt_end) begin
        r_busy <= 1'b0;
      end
      if (sample_req && r_busy && (r_drop != 4'hF)) begin
        r_drop <= r_drop + 4'd1;
      end
    end
  end

  generate
    if (AUTO_PERIOD > 0) begin : g_auto
      localparam int unsigned   TW     = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
      localparam logic [TW-1:0] T_LAST = TW'(AUTO_PERIOD - 1);
      logic [TW-1:0] r_timer;

      // Holding at T_LAST keeps an expiry pending while busy until the framer is idle.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_timer <= '0;
        end else if (w_trigger) begin
          r_timer <= '0;
        end else if (r_timer != T_LAST) begin
          r_timer <= r_timer + 1'b1;
        end
      end
      assign w_auto_fire = (r_timer == T_LAST);
    end else begin : g_no_auto
      assign w_auto_fire = 1'b0;
    end
  endgenerate

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk      (clk),
    .reset    (reset),
    .load     (w_load),
    .byte_in  (w_byte),
    .tx       (tx),
    .byte_done(w_byte_done)
  );
endmodule

// File: tb/tb_telemetry_frame_tx.sv
// Self-checking bench for telemetry_frame_tx: table-driven packets, random packets,
// async reset abort and auto-trigger scheduling against a cycle-level packet model.
`timescale 1ns/1ps
module tb_telemetry_frame_tx;
  localparam int CPB      = 4;
  localparam int PKT_CYC  = 40 * CPB;
  localparam int AUTO_CYC = 1100;

  typedef struct {
    logic [7:0] v;
    logic [7:0] d;
    logic [7:0] chk;
    int         n_drop;
    bit         on_done;
    bit         chg;
  } vec_t;

  logic clk = 1'b0;
  logic reset, rst_auto_n;
  logic [7:0] vout_in, data_in;
  logic sample_req, req_a, req_b;
  logic tx, busy, pkt_done;
  logic [3:0] drop_cnt;
  logic tx_a, busy_a, done_a, tx_b, busy_b, done_b;
  logic [3:0] drop_a, drop_b;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_drop = 0;
  int m_reqs[$];
  int m_starts[$];
  int m_drops;

  always #5 clk = ~clk;

  telemetry_frame_tx #(.CLKS_PER_BIT(CPB), .AUTO_PERIOD(0)) dut (
    .clk(clk), .reset(reset), .vout_in(vout_in), .data_in(data_in), .sample_req(sample_req),
    .tx(tx), .busy(busy), .pkt_done(pkt_done), .drop_cnt(drop_cnt));

  telemetry_frame_tx #(.CLKS_PER_BIT(CPB), .AUTO_PERIOD(200)) dut_a (
    .clk(clk), .reset(rst_auto_n), .vout_in(8'h3C), .data_in(8'hC3), .sample_req(req_a),
    .tx(tx_a), .busy(busy_a), .pkt_done(done_a), .drop_cnt(drop_a));

  telemetry_frame_tx #(.CLKS_PER_BIT(CPB), .AUTO_PERIOD(100)) dut_b (
    .clk(clk), .reset(rst_auto_n), .vout_in(8'h12), .data_in(8'h34), .sample_req(req_b),
    .tx(tx_b), .busy(busy_b), .pkt_done(done_b), .drop_cnt(drop_b));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Expected line level k cycles after the trigger edge, from the UART framing rules.
  function automatic logic exp_tx(input logic [31:0] pkt, input int k);
    int bit_idx, pos, byt;
    if (k < 1 || k > PKT_CYC) return 1'b1;
    bit_idx = (k - 1) / CPB;
    pos     = bit_idx % 10;
    byt     = bit_idx / 10;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return pkt[8*byt + pos - 1];
  endfunction

  task automatic send_packet(input logic [7:0] v, input logic [7:0] d, input logic [7:0] chk,
                             input int n_drop, input bit on_done, input bit chg);
    logic [31:0] pkt;
    logic [39:0] bits;
    logic [7:0]  got;
    int wave_err, first_err, done_at, n_done, busy_off;
    pkt = {chk, d, v, 8'hA5};
    bits = '0;
    wave_err = 0; first_err = 0; done_at = 0; n_done = 0; busy_off = 0;
    vout_in = v; data_in = d; sample_req = 1'b1;
    step();
    sample_req = 1'b0;
    if (chg) begin
      vout_in = 8'hFF;
      data_in = 8'h00;
    end
    for (int k = 1; k <= PKT_CYC + 1; k++) begin
      if (tx !== exp_tx(pkt, k)) begin
        wave_err++;
        if (first_err == 0) first_err = k;
      end
      if (((k - 1) % CPB) == CPB / 2 && k <= PKT_CYC) bits[(k - 1) / CPB] = tx;
      if (pkt_done === 1'b1) begin
        n_done++;
        done_at = k;
      end
      if (busy !== 1'b1 && busy_off == 0) busy_off = k;
      sample_req = 1'b0;
      if (k >= 3 && k < 3 + 2 * n_drop && ((k - 3) % 2) == 0) sample_req = 1'b1;
      if (k == PKT_CYC && on_done) sample_req = 1'b1;
      if (k <= PKT_CYC) step();
    end
    sample_req = 1'b0;
    exp_drop = exp_drop + n_drop + int'(on_done);
    if (exp_drop > 15) exp_drop = 15;
    check($sformatf("tx_wave_errs(first@%0d)", first_err), wave_err, 0);
    for (int b = 0; b < 4; b++) begin
      got = '0;
      for (int i = 0; i < 8; i++) got[i] = bits[b*10 + 1 + i];
      check($sformatf("byte%0d", b), got, pkt[8*b +: 8]);
    end
    check("pkt_done_count", n_done, 1);
    check("pkt_done_cycle", done_at, PKT_CYC);
    check("busy_drop_cycle", busy_off, PKT_CYC + 1);
    check("drop_cnt", drop_cnt, exp_drop);
    $display("[TB] packet vout=%02h data=%02h chk=%02h drop_cnt=%0d", v, d, chk, drop_cnt);
  endtask

  // Abstract schedule: each start follows max(timer expiry, end of previous packet),
  // or an earlier idle request; requests during a packet are drops.
  task automatic run_model(input int period, input int horizon);
    int base, idle_at, nxt, ri;
    m_starts.delete();
    base = 0; idle_at = 1; ri = 0; m_drops = 0;
    while (1) begin
      nxt = base + period;
      if (nxt < idle_at) nxt = idle_at;
      while (ri < m_reqs.size() && m_reqs[ri] < idle_at) begin
        m_drops++;
        ri++;
      end
      if (ri < m_reqs.size() && m_reqs[ri] < nxt) nxt = m_reqs[ri];
      if (ri < m_reqs.size() && m_reqs[ri] == nxt) ri++;
      if (nxt > horizon) break;
      m_starts.push_back(nxt);
      base = nxt;
      idle_at = nxt + PKT_CYC + 1;
    end
    if (m_drops > 15) m_drops = 15;
  endtask

  initial begin
    vec_t vecs[6];
    int reqs_a[$];
    int reqs_b[$];
    int starts_a[$];
    int starts_b[$];
    int exp_a[$];
    int exp_b[$];
    int bad, drops_a_exp, drops_b_exp;
    logic pa, pb;
    logic [7:0] rv, rd;

    vecs[0] = '{8'h14, 8'h32, 8'h83, 0,  1'b0, 1'b0};
    vecs[1] = '{8'h0A, 8'h64, 8'hCB, 0,  1'b0, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 8'hA5, 0,  1'b1, 1'b0};
    vecs[3] = '{8'hFF, 8'hFF, 8'hA5, 20, 1'b1, 1'b0};
    vecs[4] = '{8'hFF, 8'h00, 8'h5A, 0,  1'b0, 1'b0};
    vecs[5] = '{8'h5A, 8'hA5, 8'h5A, 2,  1'b0, 1'b1};

    reset = 1'b0; rst_auto_n = 1'b0;
    sample_req = 1'b0; req_a = 1'b0; req_b = 1'b0;
    vout_in = '0; data_in = '0;
    repeat (3) step();
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_pkt_done", pkt_done, 0);
    check("reset_drop_cnt", drop_cnt, 0);
    reset = 1'b1;
    repeat (2) step();
    check("post_reset_tx", tx, 1);
    check("post_reset_busy", busy, 0);
    check("post_reset_drop_cnt", drop_cnt, 0);

    for (int i = 0; i < 6; i++)
      send_packet(vecs[i].v, vecs[i].d, vecs[i].chk, vecs[i].n_drop, vecs[i].on_done, vecs[i].chg);

    // Abort mid byte 1 (vout=0 so the line is low when reset hits).
    vout_in = 8'h00; data_in = 8'h55; sample_req = 1'b1;
    step();
    sample_req = 1'b0;
    repeat (49) step();
    check("pre_reset_tx", tx, 0);
    check("pre_reset_busy", busy, 1);
    #3 reset = 1'b0;
    #1;
    check("async_reset_tx", tx, 1);
    check("async_reset_busy", busy, 0);
    check("async_reset_drop_cnt", drop_cnt, 0);
    exp_drop = 0;
    repeat (3) step();
    reset = 1'b1;
    bad = 0;
    for (int c = 0; c < 200; c++) begin
      step();
      if (tx !== 1'b1 || pkt_done !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("no_resume_after_reset", bad, 0);
    $display("[TB] reset abort: idle cycles with activity=%0d", bad);

    for (int i = 0; i < 5; i++) begin
      rv = 8'($urandom);
      rd = 8'($urandom);
      repeat ($urandom_range(0, 3)) step();
      send_packet(rv, rd, 8'hA5 ^ rv ^ rd, int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), 1'b1);
    end

    // Auto-trigger: requests listed by the clock edge at which they are sampled.
    reqs_a = '{400, 450, 780};
    reqs_b = '{422};
    m_reqs = reqs_a;
    run_model(200, AUTO_CYC);
    exp_a = m_starts;
    drops_a_exp = m_drops;
    m_reqs = reqs_b;
    run_model(100, AUTO_CYC);
    exp_b = m_starts;
    drops_b_exp = m_drops;

    pa = 1'b0; pb = 1'b0;
    rst_auto_n = 1'b1;
    for (int c = 1; c <= AUTO_CYC; c++) begin
      req_a = 1'b0;
      req_b = 1'b0;
      foreach (reqs_a[i]) if (reqs_a[i] == c) req_a = 1'b1;
      foreach (reqs_b[i]) if (reqs_b[i] == c) req_b = 1'b1;
      step();
      if (busy_a === 1'b1 && !pa) starts_a.push_back(c);
      if (busy_b === 1'b1 && !pb) starts_b.push_back(c);
      pa = busy_a;
      pb = busy_b;
    end
    req_a = 1'b0;
    req_b = 1'b0;

    check("auto200_start_count", starts_a.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < starts_a.size(); i++)
      check($sformatf("auto200_start%0d", i), starts_a[i], exp_a[i]);
    check("auto200_drop_cnt", drop_a, drops_a_exp);
    check("auto100_start_count", starts_b.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < starts_b.size(); i++)
      check($sformatf("auto100_start%0d", i), starts_b[i], exp_b[i]);
    check("auto100_drop_cnt", drop_b, drops_b_exp);
    $display("[TB] auto200: %0d packets, drop_cnt=%0d; auto100: %0d packets, drop_cnt=%0d",
             starts_a.size(), drop_a, starts_b.size(), drop_b);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
